cr_kme_fifo_reader: RTL and testbench

CR_KME_FIFO_READER -- requirements
Module: cr_kme_fifo_reader

---
 rtl/cr_kme_fifo_reader.sv | 158 +++++++++++++++
 tb/tb_cr_kme_fifo_reader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_kme_fifo_reader.sv
// cr_kme_fifo_reader: pops framed entries from a FIFO into a 2-entry
// skid buffer and streams them downstream with frame tracking and flush.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   fifo_out[70:0]  - FIFO head entry, bit 70 = last, 69:0 = payload
//   fifo_out_valid  - FIFO non-empty
//   fifo_out_ack    - pop strobe to FIFO
//   flush_req       - pulse: discard through next last-flagged entry
//   out_data/out_last/out_valid/out_ready - downstream handshake
//   frame_count     - frames delivered (saturating)
//   flushing        - FSM in FLUSH
//   proto_err       - sticky internal protocol error
// Option: CR_KME_RD_FRAME_CNT_EN enables the frame counter; otherwise
// frame_count is tied to zero.
module cr_kme_fifo_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic [70:0] fifo_out,
  input  logic        fifo_out_valid,
  output logic        fifo_out_ack,
  input  logic        flush_req,
  output logic [69:0] out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frame_count,
  output logic        flushing,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE,
    IN_FRAME,
    FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic [69:0] d0_q, d1_q, d0_d, d1_d;
  logic        l0_q, l1_q, l0_d, l1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  cnt_pop;
  logic        pop, acc, push, start_flush;
  logic        in_last;
  logic        proto_d;

  assign in_last   = fifo_out[70];
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = d0_q;
  assign out_last  = l0_q;
  assign flushing  = (state_q == FLUSH);

  assign pop     = out_valid & out_ready;
  assign cnt_pop = cnt_q - {1'b0, pop};

  // In FLUSH entries are discarded, so room in the skid is irrelevant.
  assign fifo_out_ack = ~rst & fifo_out_valid &
                        ((cnt_pop != 2'd2) | flushing);

  assign acc         = fifo_out_ack;
  assign start_flush = flush_req & ~flushing;
  // An entry accepted in the flush cycle belongs to the discarded run.
  assign push        = acc & ~start_flush & ~flushing;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (acc && !in_last) state_d = IN_FRAME;
      IN_FRAME: if (acc && in_last)  state_d = IDLE;
      FLUSH:    if (acc && in_last)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (start_flush) begin
      state_d = (acc && in_last) ? IDLE : FLUSH;
    end
  end

  always_comb begin
    d0_d  = d0_q;
    d1_d  = d1_q;
    l0_d  = l0_q;
    l1_d  = l1_q;
    cnt_d = cnt_q;
    if (start_flush) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({pop, push})
        2'b10: begin
          d0_d  = d1_q;
          l0_d  = l1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd0) begin
            d0_d = fifo_out[69:0];
            l0_d = in_last;
          end else begin
            d1_d = fifo_out[69:0];
            l1_d = in_last;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            d0_d = fifo_out[69:0];
            l0_d = in_last;
          end else begin
            d0_d = d1_q;
            l0_d = l1_q;
            d1_d = fifo_out[69:0];
            l1_d = in_last;
          end
        end
        default: ;
      endcase
    end
  end

  // Head vanishing without a transfer is only legal via a flush.
  assign proto_d = out_valid & ~pop & ~start_flush &
                   (cnt_d == 2'd0) & (state_d != FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      d0_q      <= '0;
      d1_q      <= '0;
      l0_q      <= 1'b0;
      l1_q      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      l0_q      <= l0_d;
      l1_q      <= l1_d;
      proto_err <= proto_err | proto_d;
    end
  end

`ifdef CR_KME_RD_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (pop && l0_q && frame_cnt_q != 16'hFFFF) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_cr_kme_fifo_reader.sv
// tb_cr_kme_fifo_reader: directed table vectors plus hand sequences
// for streaming, backpressure, flush, reset and empty-FIFO cases.
module tb_cr_kme_fifo_reader;

`ifdef CR_KME_RD_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [70:0] fifo_out;
  logic        fifo_out_valid;
  logic        fifo_out_ack;
  logic        flush_req;
  logic [69:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] frame_count;
  logic        flushing;
  logic        proto_err;

  always #5 clk = ~clk;

  cr_kme_fifo_reader dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_out       (fifo_out),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ack   (fifo_out_ack),
    .flush_req      (flush_req),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .frame_count    (frame_count),
    .flushing       (flushing),
    .proto_err      (proto_err)
  );

  typedef struct {
    logic        fv;
    logic [69:0] d;
    logic        l;
    logic        rdy;
    logic        fl;
    logic        e_ack;
    logic        e_ov;
    logic [69:0] e_d;
    logic        e_l;
    logic        e_fl;
    int          e_fc;
  } vec_t;

  vec_t        tv[17];
  logic [70:0] q[$];
  logic [70:0] rx[$];
  bit          qmode;
  int          n_err;
  int          n_chk;

  function automatic vec_t mk(
    input logic fv, input logic [69:0] d, input logic l,
    input logic rdy, input logic fl, input logic e_ack,
    input logic e_ov, input logic [69:0] e_d, input logic e_l,
    input logic e_fl, input int e_fc);
    vec_t v;
    v.fv = fv; v.d = d; v.l = l; v.rdy = rdy; v.fl = fl;
    v.e_ack = e_ack; v.e_ov = e_ov; v.e_d = e_d; v.e_l = e_l;
    v.e_fl = e_fl; v.e_fc = e_fc;
    return v;
  endfunction

  function automatic logic [15:0] efc(input int n);
    return FC_EN ? 16'(n) : 16'd0;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_out_valid = (q.size() != 0);
    fifo_out       = (q.size() != 0) ? q[0] : 71'd0;
  endtask

  task automatic step();
    logic f;
    #2;
    f = fifo_out_valid && fifo_out_ack;
    if (out_valid && out_ready) rx.push_back({out_last, out_data});
    @(posedge clk);
    #1;
    if (qmode) begin
      if (f) void'(q.pop_front());
      drive_fifo();
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    q.delete();
    qmode     = 1'b1;
    drive_fifo();
    flush_req = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    rx.delete();
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;

    tv[0]  = mk(1, 70'hA1, 0, 0, 0, 1, 1, 70'hA1, 0, 0, 0);
    tv[1]  = mk(1, 70'hA2, 0, 0, 0, 1, 1, 70'hA1, 0, 0, 0);
    tv[2]  = mk(1, 70'hA3, 1, 0, 0, 0, 1, 70'hA1, 0, 0, 0);
    tv[3]  = mk(1, 70'hA3, 1, 1, 0, 1, 1, 70'hA2, 0, 0, 0);
    tv[4]  = mk(0, 70'h0,  0, 1, 0, 0, 1, 70'hA3, 1, 0, 0);
    tv[5]  = mk(0, 70'h0,  0, 1, 0, 0, 0, 70'h0,  0, 0, 1);
    tv[6]  = mk(1, 70'hB1, 1, 1, 0, 1, 1, 70'hB1, 1, 0, 1);
    tv[7]  = mk(0, 70'h0,  0, 0, 0, 0, 1, 70'hB1, 1, 0, 1);
    tv[8]  = mk(0, 70'h0,  0, 1, 0, 0, 0, 70'h0,  0, 0, 2);
    tv[9]  = mk(1, 70'hC1, 0, 1, 0, 1, 1, 70'hC1, 0, 0, 2);
    tv[10] = mk(1, 70'hC2, 0, 0, 1, 1, 0, 70'h0,  0, 1, 2);
    tv[11] = mk(1, 70'hC3, 0, 1, 0, 1, 0, 70'h0,  0, 1, 2);
    tv[12] = mk(1, 70'hC4, 1, 1, 0, 1, 0, 70'h0,  0, 0, 2);
    tv[13] = mk(1, 70'hD1, 1, 1, 0, 1, 1, 70'hD1, 1, 0, 2);
    tv[14] = mk(0, 70'h0,  0, 1, 1, 0, 0, 70'h0,  0, 1, 3);
    tv[15] = mk(1, 70'hE1, 1, 1, 1, 1, 0, 70'h0,  0, 0, 3);
    tv[16] = mk(0, 70'h0,  0, 1, 0, 0, 0, 70'h0,  0, 0, 3);

    do_reset();
    #1;
    chk("rst_ack", 72'(fifo_out_ack), 72'd0);
    chk("rst_ov", 72'(out_valid), 72'd0);
    chk("rst_data", 72'({out_last, out_data}), 72'd0);
    chk("rst_fc", 72'(frame_count), 72'd0);
    chk("rst_fl", 72'(flushing), 72'd0);
    chk("rst_perr", 72'(proto_err), 72'd0);

    qmode = 1'b0;
    for (int i = 0; i < 17; i++) begin
      fifo_out_valid = tv[i].fv;
      fifo_out       = {tv[i].l, tv[i].d};
      out_ready      = tv[i].rdy;
      flush_req      = tv[i].fl;
      #1;
      chk($sformatf("vec%0d_ack", i), 72'(fifo_out_ack),
          72'(tv[i].e_ack));
      step();
      chk($sformatf("vec%0d_ov", i), 72'(out_valid), 72'(tv[i].e_ov));
      if (tv[i].e_ov)
        chk($sformatf("vec%0d_data", i), 72'({out_last, out_data}),
            72'({tv[i].e_l, tv[i].e_d}));
      chk($sformatf("vec%0d_flushing", i), 72'(flushing),
          72'(tv[i].e_fl));
      chk($sformatf("vec%0d_fc", i), 72'(frame_count),
          72'(efc(tv[i].e_fc)));
      chk($sformatf("vec%0d_perr", i), 72'(proto_err), 72'd0);
    end

    // back-to-back streaming of an 8-beat frame
    do_reset();
    for (int i = 0; i < 8; i++)
      q.push_back({i == 7, 70'h100 + 70'(i)});
    out_ready = 1'b1;
    drive_fifo();
    #1;
    chk("stream_first_ack", 72'(fifo_out_ack), 72'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("stream_ov%0d", i), 72'(out_valid), 72'd1);
      chk($sformatf("stream_beat%0d", i), 72'({out_last, out_data}),
          72'({i == 7, 70'h100 + 70'(i)}));
    end
    step();
    chk("stream_end_ov", 72'(out_valid), 72'd0);
    chk("stream_fc", 72'(frame_count), 72'(efc(1)));

    // backpressure with a full FIFO
    begin
      int n_ack;
      do_reset();
      for (int i = 0; i < 6; i++)
        q.push_back({i == 5, 70'h200 + 70'(i)});
      drive_fifo();
      n_ack = 0;
      for (int c = 0; c < 5; c++) begin
        #1;
        if (fifo_out_ack) n_ack++;
        step();
        chk($sformatf("bp_hold%0d", c), 72'({out_valid, out_data}),
            72'({1'b1, 70'h200}));
      end
      chk("bp_acks", 72'(n_ack), 72'd2);
      #1;
      chk("bp_ack_low", 72'(fifo_out_ack), 72'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 20 && rx.size() < 6; c++) step();
      chk("bp_beats", 72'(rx.size()), 72'd6);
      for (int i = 0; i < rx.size() && i < 6; i++)
        chk($sformatf("bp_rx%0d", i), 72'(rx[i]),
            72'({i == 5, 70'h200 + 70'(i)}));
      chk("bp_fc", 72'(frame_count), 72'(efc(1)));
    end

    // flush after 3 of 6 beats
    do_reset();
    for (int i = 0; i < 6; i++)
      q.push_back({i == 5, 70'h300 + 70'(i)});
    out_ready = 1'b1;
    drive_fifo();
    step();
    step();
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("fl_rx_cnt", 72'(rx.size()), 72'd3);
    if (rx.size() == 3)
      chk("fl_rx2", 72'(rx[2]), 72'({1'b0, 70'h302}));
    chk("fl_c1", 72'({out_valid, flushing}), 72'b01);
    step();
    chk("fl_c2", 72'({out_valid, flushing}), 72'b01);
    step();
    chk("fl_done", 72'({out_valid, flushing}), 72'b00);
    chk("fl_q_empty", 72'(q.size()), 72'd0);
    chk("fl_fc", 72'(frame_count), 72'd0);
    step();
    chk("fl_rx_final", 72'(rx.size()), 72'd3);

    // reset in the middle of a frame
    do_reset();
    for (int i = 0; i < 4; i++)
      q.push_back({i == 3, 70'h400 + 70'(i)});
    out_ready = 1'b1;
    drive_fifo();
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mrst_ack", 72'(fifo_out_ack), 72'd0);
    step();
    rst = 1'b0;
    q.delete();
    drive_fifo();
    chk("mrst_out", 72'({out_valid, out_last, out_data}), 72'd0);
    chk("mrst_st", 72'({frame_count, flushing, proto_err}), 72'd0);
    q.push_back({1'b1, 70'h4F0});
    drive_fifo();
    rx.delete();
    step();
    step();
    chk("mrst_rx", 72'(rx.size() == 1 ? rx[0] : 71'd0),
        72'({1'b1, 70'h4F0}));
    chk("mrst_fc", 72'(frame_count), 72'(efc(1)));

`ifdef CR_KME_RD_FRAME_CNT_EN
    // saturation of the frame counter
    do_reset();
    force dut.frame_cnt_q = 16'hFFFE;
    step();
    release dut.frame_cnt_q;
    chk("sat_pre", 72'(frame_count), 72'hFFFE);
    for (int i = 0; i < 3; i++) q.push_back({1'b1, 70'h500 + 70'(i)});
    out_ready = 1'b1;
    drive_fifo();
    step();
    step();
    chk("sat_first", 72'(frame_count), 72'hFFFF);
    for (int c = 0; c < 4; c++) step();
    chk("sat_final", 72'(frame_count), 72'hFFFF);
    chk("sat_rx", 72'(rx.size()), 72'd3);
`endif

    // empty FIFO for 20 cycles
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk($sformatf("empty_ack%0d", c), 72'(fifo_out_ack), 72'd0);
      step();
      chk($sformatf("empty_ov%0d", c), 72'({out_valid, proto_err}),
          72'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
